// File: rtl/oled_pkg.sv
// ---------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the 96x64 OLED screen path.
//   - Panel geometry (width, height, pixel count).
//   - RGB565 colour constants used by the scheduler and the renderers.
//   - Screen-scheduler state encoding.
//   - in_frame(): true when a pixel index addresses a real panel pixel.
// ---------------------------------------------------------------------------
package oled_pkg;

  localparam int OLED_W      = 96;
  localparam int OLED_H      = 64;
  localparam int OLED_PIXELS = OLED_W * OLED_H;

  // RGB565 colours
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] BLUE    = 16'h001F;
  localparam logic [15:0] MAGENTA = 16'hF81F;
  localparam logic [15:0] CYAN    = 16'h07FF;
  localparam logic [15:0] YELLOW  = 16'hFFE0;

  // IDLE: waiting for the first frame, SHOW: a renderer drives the panel,
  // BLANK: black frames between two screens.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } screen_state_t;

  // The OLED driver may present indices past the last pixel; those are
  // treated as off-panel.
  function automatic logic in_frame(input logic [12:0] idx);
    return idx < 13'(OLED_PIXELS);
  endfunction

endpackage

// File: rtl/oled_pixel_xy.sv
// ---------------------------------------------------------------------------
// oled_pixel_xy
// Converts a row-major pixel index into panel coordinates.
// Off-panel indices (>= 6144) report x=0, y=0 and valid=0 so that renderers
// and the scheduler can blank them.
// Ports:
//   pixel_index  in  13  row-major pixel index from the OLED driver
//   x            out  7  column, pixel_index % 96
//   y            out  6  row, pixel_index / 96
//   valid        out  1  pixel_index addresses a real panel pixel
// ---------------------------------------------------------------------------
module oled_pixel_xy
  import oled_pkg::*;
(
  input  logic [12:0] pixel_index,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic        valid
);

  always_comb begin
    valid = in_frame(pixel_index);
    x     = '0;
    y     = '0;
    if (valid) begin
      x = 7'(pixel_index % 13'(OLED_W));
      y = 6'(pixel_index / 13'(OLED_W));
    end
  end

endmodule

// File: rtl/oled_screen_scheduler.sv
// ---------------------------------------------------------------------------
// oled_screen_scheduler
// Chooses which of NUM_SCREENS renderers drives the OLED pixel stream.
// Screen changes happen only on frame boundaries and are separated by
// BLANK_FRAMES whole black frames. With auto_en high, each screen is shown
// for AUTO_FRAMES frames before the scheduler advances to the next one.
// Ports:
//   clk            in   1       system clock
//   rst_n          in   1       asynchronous active-low reset
//   frame_begin    in   1       pulse when pixel_index returns to 0
//   pixel_index    in   13      current pixel from the OLED driver
//   req            in   N       screen request pulses, lowest index wins
//   auto_en        in   1       enables auto-advance
//   screen_data    in   16*N    renderer colours, slice i = screen i
//   x, y           out  7/6     coordinates of pixel_index for the renderers
//   oled_data      out  16      registered colour, 1 clk after pixel_index
//   active_screen  out  SW      screen shown (or the target while blanking)
//   switching      out  1       high while blanking between screens
// ---------------------------------------------------------------------------
module oled_screen_scheduler
  import oled_pkg::*;
#(
  parameter  int NUM_SCREENS  = 4,
  parameter  int BLANK_FRAMES = 2,
  parameter  int AUTO_FRAMES  = 120,
  localparam int SW           = $clog2(NUM_SCREENS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_begin,
  input  logic [12:0]               pixel_index,
  input  logic [NUM_SCREENS-1:0]    req,
  input  logic                      auto_en,
  input  logic [16*NUM_SCREENS-1:0] screen_data,
  output logic [6:0]                x,
  output logic [5:0]                y,
  output logic [15:0]               oled_data,
  output logic [SW-1:0]             active_screen,
  output logic                      switching
);

  localparam int FW = $clog2(AUTO_FRAMES + 1);
  localparam int BW = $clog2(BLANK_FRAMES + 1);

  screen_state_t   state;
  screen_state_t   state_nxt;
  logic [SW-1:0]   active_nxt;
  logic [SW-1:0]   pending;
  logic            pend_vld;
  logic [SW-1:0]   req_idx;
  logic            req_any;
  logic [FW-1:0]   frame_cnt;
  logic [BW-1:0]   blank_cnt;
  logic            pix_valid;
  logic            req_switch;
  logic            auto_adv;
  logic            blank_done;
  logic            blank_retarget;
  logic [15:0]     pixel_nxt;
  logic [15:0]     slices [NUM_SCREENS];

  // Coordinates go straight to the renderers; the valid flag blanks
  // off-panel indices in the output register.
  oled_pixel_xy u_pixel_xy (
    .pixel_index (pixel_index),
    .x           (x),
    .y           (y),
    .valid       (pix_valid)
  );

  // Lowest set request bit wins when several arrive together.
  always_comb begin
    req_any = |req;
    req_idx = '0;
    for (int i = NUM_SCREENS - 1; i >= 0; i--) begin
      if (req[i]) req_idx = SW'(i);
    end
  end

  // Frame-boundary decisions. They use the pending request registered
  // before this cycle, so a request arriving together with frame_begin is
  // only acted on at the following frame boundary.
  always_comb begin
    req_switch     = frame_begin && (state == SHOW) && pend_vld &&
                     (pending != active_screen);
    auto_adv       = frame_begin && (state == SHOW) && !pend_vld && auto_en &&
                     (frame_cnt == FW'(AUTO_FRAMES - 1));
    blank_done     = frame_begin && (state == BLANK) &&
                     (blank_cnt == BW'(BLANK_FRAMES - 1));
    blank_retarget = frame_begin && (state == BLANK) && pend_vld;

    state_nxt = state;
    case (state)
      IDLE:    if (frame_begin) state_nxt = SHOW;
      SHOW:    if (req_switch || auto_adv) state_nxt = BLANK;
      BLANK:   if (blank_done) state_nxt = SHOW;
      default: state_nxt = IDLE;
    endcase

    active_nxt = active_screen;
    if (req_switch || blank_retarget) begin
      active_nxt = pending;
    end else if (auto_adv) begin
      active_nxt = (active_screen == SW'(NUM_SCREENS - 1)) ? '0
                                                            : active_screen + SW'(1);
    end
  end

  // The pixel register looks at the state and screen that take effect on
  // this edge, so pixel 0 of each frame already belongs to the new screen
  // (or to the blanking) and every blank frame is black from its first pixel.
  always_comb begin
    for (int i = 0; i < NUM_SCREENS; i++) begin
      slices[i] = screen_data[i*16 +: 16];
    end
    pixel_nxt = BLACK;
    if (pix_valid && (state_nxt == SHOW)) pixel_nxt = slices[active_nxt];
  end

  // Scheduler FSM with its counters, request capture and output registers.
  // A new request always lands after the frame-boundary bookkeeping so a
  // request in a frame_begin cycle survives the pend_vld clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      active_screen <= '0;
      pending       <= '0;
      pend_vld      <= 1'b0;
      frame_cnt     <= '0;
      blank_cnt     <= '0;
      oled_data     <= BLACK;
      switching     <= 1'b0;
    end else begin
      state         <= state_nxt;
      active_screen <= active_nxt;
      switching     <= (state_nxt == BLANK);
      oled_data     <= pixel_nxt;

      if (frame_begin) begin
        case (state)
          IDLE: begin
            frame_cnt <= '0;
          end
          SHOW: begin
            if (pend_vld) begin
              pend_vld <= 1'b0;
              if (req_switch) blank_cnt <= '0;
            end else if (auto_adv) begin
              blank_cnt <= '0;
            end else if (!auto_en) begin
              frame_cnt <= '0;
            end else if (frame_cnt != FW'(AUTO_FRAMES - 1)) begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
          BLANK: begin
            if (pend_vld) pend_vld <= 1'b0;
            if (blank_done) frame_cnt <= '0;
            else            blank_cnt <= blank_cnt + BW'(1);
          end
          default: begin
          end
        endcase
      end

      if (req_any) begin
        pending  <= req_idx;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oled_screen_scheduler.sv
// ---------------------------------------------------------------------------
// tb_oled_screen_scheduler
// Directed bench for oled_screen_scheduler with NUM_SCREENS=4,
// BLANK_FRAMES=2, AUTO_FRAMES=3. Frames are shortened to a fixed list of
// pixel indices. Renderer i paints {1, i, y, x}, so every output pixel
// identifies both the screen and the coordinates it came from.
// ---------------------------------------------------------------------------
module tb_oled_screen_scheduler;

   localparam int NumScreens  = 4;
   localparam int BlankFrames = 2;
   localparam int AutoFrames  = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_begin = 1'b0;
   logic [12:0] pixel_index = '0;
   logic [3:0]  req = '0;
   logic        auto_en = 1'b0;
   logic [63:0] screen_data;
   logic [6:0]  x;
   logic [5:0]  y;
   logic [15:0] oled_data;
   logic [1:0]  active_screen;
   logic        switching;

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 waiting, 1 showing, 2 blanking
   int          mMode = 0;
   int          mScreen = 0;
   int          mPend = -1;
   int          mShown = 0;
   int          mBlankLeft = 0;
   logic [15:0] mExpOled = '0;

   int pixList [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 95, 96, 97, 191, 192, 6143, 6200, 6143};

   always #5 clk = ~clk;

   oled_screen_scheduler #(
      .NUM_SCREENS  (NumScreens),
      .BLANK_FRAMES (BlankFrames),
      .AUTO_FRAMES  (AutoFrames)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_begin   (frame_begin),
      .pixel_index   (pixel_index),
      .req           (req),
      .auto_en       (auto_en),
      .screen_data   (screen_data),
      .x             (x),
      .y             (y),
      .oled_data     (oled_data),
      .active_screen (active_screen),
      .switching     (switching)
   );

   // Renderers: each screen paints a colour made of its index and the
   // coordinates it is given.
   always_comb begin
      screen_data = '0;
      for (int i = 0; i < NumScreens; i++) begin
         screen_data[i*16 +: 16] = {1'b1, 2'(i), y, x};
      end
   end

   // What a renderer should paint for a pixel, derived from the raw index.
   function automatic logic [15:0] expPixel(input int scr, input int pix);
      if (pix >= 6144) return 16'h0000;
      return {1'b1, 2'(scr), 6'(pix / 96), 7'(pix % 96)};
   endfunction

   // One comparison; every failure prints a single FAIL line.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one shortened frame: frame_begin on the first pixel, an optional
   // request on pixel slot reqAt, and auto_en held at aut for the frame.
   task automatic applyStimulus(input logic [3:0] reqv, input int reqAt, input logic aut);
      for (int k = 0; k < 16; k++) begin
         pixel_index = 13'(pixList[k]);
         frame_begin = (k == 0);
         req         = (k == reqAt) ? reqv : 4'b0000;
         auto_en     = aut;
         @(posedge clk);
         #1;
      end
      frame_begin = 1'b0;
      req         = 4'b0000;
   endtask

   // Scheduler rules in frame terms: a screen that has been up for
   // AutoFrames whole frames under auto mode gives way to the next one,
   // every change costs BlankFrames black frames, and the newest request
   // (lowest bit) is honoured at the next frame boundary.
   task automatic modelStep();
      int pix;
      pix = int'(pixel_index);
      if (frame_begin) begin
         if (mMode == 0) begin
            mMode  = 1;
            mShown = 0;
         end else if (mMode == 1) begin
            if (mPend >= 0) begin
               if (mPend != mScreen) begin
                  mScreen    = mPend;
                  mMode      = 2;
                  mBlankLeft = BlankFrames;
               end
               mPend = -1;
            end else if (auto_en && (mShown + 1 >= AutoFrames)) begin
               mScreen    = (mScreen + 1) % NumScreens;
               mMode      = 2;
               mBlankLeft = BlankFrames;
            end else begin
               mShown = auto_en ? mShown + 1 : 0;
            end
         end else begin
            if (mPend >= 0) begin
               mScreen = mPend;
               mPend   = -1;
            end
            mBlankLeft--;
            if (mBlankLeft == 0) begin
               mMode  = 1;
               mShown = 0;
            end
         end
      end
      if (req != 4'b0000) begin
         for (int i = 3; i >= 0; i--) begin
            if (req[i]) mPend = i;
         end
      end
      mExpOled = (mMode == 1) ? expPixel(mScreen, pix) : 16'h0000;
   endtask

   // Model advances on every rising edge; reset puts it back to waiting.
   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            mMode    = 0;
            mScreen  = 0;
            mPend    = -1;
            mShown   = 0;
            mExpOled = 16'h0000;
         end else begin
            modelStep();
         end
      end
   end

   // Per-cycle comparison on the falling edge, away from the active edge.
   initial begin
      int pix;
      forever begin
         @(negedge clk);
         pix = int'(pixel_index);
         if (!rst_n) begin
            checkOutput("rst_oled", 32'(oled_data), 32'h0);
            checkOutput("rst_active", 32'(active_screen), 32'h0);
            checkOutput("rst_switching", 32'(switching), 32'h0);
         end else begin
            checkOutput("oled_data", 32'(oled_data), 32'(mExpOled));
            checkOutput("active_screen", 32'(active_screen), 32'(mScreen));
            checkOutput("switching", 32'(switching), 32'(mMode == 2));
         end
         checkOutput("x", 32'(x), (pix < 6144) ? 32'(pix % 96) : 32'h0);
         checkOutput("y", 32'(y), (pix < 6144) ? 32'(pix / 96) : 32'h0);
      end
   end

   // Directed sequence with hand-computed expectations pinning the model.
   initial begin
      $display("[TB] start");
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_oled", 32'(oled_data), 32'h0);
      checkOutput("reset_active", 32'(active_screen), 32'h0);
      checkOutput("reset_switching", 32'(switching), 32'h0);
      rst_n = 1'b1;

      // Before the first frame the panel stays black.
      pixel_index = 13'd97;
      #1;
      checkOutput("x_97", 32'(x), 32'd1);
      checkOutput("y_97", 32'(y), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("idle_black", 32'(oled_data), 32'h0);

      // First frame_begin starts screen 0.
      $display("[TB] idle to show");
      applyStimulus(4'b0000, -1, 1'b0);
      pixel_index = 13'd97;
      @(posedge clk);
      #1;
      checkOutput("show0_px97", 32'(oled_data), 32'h8081);
      checkOutput("show0_active", 32'(active_screen), 32'd0);

      // Request screen 2 mid-frame: two black frames, then screen 2.
      $display("[TB] request screen 2");
      applyStimulus(4'b0100, 5, 1'b0);
      checkOutput("req_pending_still_show", 32'(switching), 32'd0);
      applyStimulus(4'b0000, -1, 1'b0);
      checkOutput("blank1_switching", 32'(switching), 32'd1);
      checkOutput("blank1_active", 32'(active_screen), 32'd2);
      applyStimulus(4'b0000, -1, 1'b0);
      checkOutput("blank2_switching", 32'(switching), 32'd1);
      applyStimulus(4'b0000, -1, 1'b0);
      checkOutput("show2_switching", 32'(switching), 32'd0);
      pixel_index = 13'd97;
      @(posedge clk);
      #1;
      checkOutput("show2_px97", 32'(oled_data), 32'hC081);

      // Two bits at once pick screen 1; a request during blanking retargets.
      $display("[TB] multi-bit request and retarget");
      applyStimulus(4'b0110, 3, 1'b0);
      applyStimulus(4'b1000, 4, 1'b0);
      checkOutput("retarget_before", 32'(active_screen), 32'd1);
      applyStimulus(4'b0000, -1, 1'b0);
      checkOutput("retarget_after", 32'(active_screen), 32'd3);
      checkOutput("retarget_blank2", 32'(switching), 32'd1);
      applyStimulus(4'b0000, -1, 1'b0);
      checkOutput("retarget_show", 32'(switching), 32'd0);
      pixel_index = 13'd97;
      @(posedge clk);
      #1;
      checkOutput("show3_px97", 32'(oled_data), 32'hE081);

      // Auto mode: screen 3 shown three frames, then wraps to screen 0.
      $display("[TB] auto advance");
      applyStimulus(4'b0000, -1, 1'b1);
      applyStimulus(4'b0000, -1, 1'b1);
      checkOutput("auto_hold3", 32'(switching), 32'd0);
      applyStimulus(4'b0000, -1, 1'b1);
      checkOutput("auto_blank", 32'(switching), 32'd1);
      checkOutput("auto_wrap", 32'(active_screen), 32'd0);
      applyStimulus(4'b0000, -1, 1'b1);
      applyStimulus(4'b0000, -1, 1'b1);
      checkOutput("auto_show0", 32'(switching), 32'd0);

      // Dropping auto_en for one frame restarts the count.
      applyStimulus(4'b0000, -1, 1'b1);
      applyStimulus(4'b0000, -1, 1'b0);
      applyStimulus(4'b0000, -1, 1'b1);
      applyStimulus(4'b0000, -1, 1'b1);
      checkOutput("auto_drop_no_adv", 32'(switching), 32'd0);
      checkOutput("auto_drop_active", 32'(active_screen), 32'd0);
      auto_en = 1'b0;

      // Last pixel and an off-panel index.
      $display("[TB] coordinate boundaries");
      pixel_index = 13'd6143;
      #1;
      checkOutput("x_6143", 32'(x), 32'd95);
      checkOutput("y_6143", 32'(y), 32'd63);
      @(posedge clk);
      #1;
      checkOutput("px_6143", 32'(oled_data), 32'h9FDF);
      pixel_index = 13'd6200;
      #1;
      checkOutput("x_6200", 32'(x), 32'd0);
      checkOutput("y_6200", 32'(y), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("px_6200", 32'(oled_data), 32'h0);

      // No frame_begin for a while: nothing changes.
      for (int i = 0; i < 40; i++) begin
         pixel_index = 13'(i * 7);
         @(posedge clk);
         #1;
      end
      checkOutput("no_frame_hold", 32'(switching), 32'd0);

      // Request in the frame_begin cycle waits for the next boundary.
      $display("[TB] request on frame boundary");
      applyStimulus(4'b0010, 0, 1'b0);
      checkOutput("same_cycle_defer", 32'(switching), 32'd0);
      checkOutput("same_cycle_active", 32'(active_screen), 32'd0);
      applyStimulus(4'b0000, -1, 1'b0);
      checkOutput("same_cycle_blank", 32'(switching), 32'd1);
      checkOutput("same_cycle_target", 32'(active_screen), 32'd1);

      // Asynchronous reset while blanking, between clock edges.
      $display("[TB] async reset during blank");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_oled", 32'(oled_data), 32'h0);
      checkOutput("async_active", 32'(active_screen), 32'd0);
      checkOutput("async_switching", 32'(switching), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(4'b0000, -1, 1'b0);
      pixel_index = 13'd97;
      @(posedge clk);
      #1;
      checkOutput("post_reset_px97", 32'(oled_data), 32'h8081);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
